// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller: FSM states,
// memory-wait limit, counter widths and the load-use match helper.
package pipeline_hazard_ctrl_pkg;

  localparam int WAIT_LIMIT = 255;
  localparam int WAIT_W     = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  // True when the ID instruction reads a register the EX load writes.
  // x0 never carries a real dependency.
  function automatic logic load_use_hit(
    input logic       memtoreg,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       uses_rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    logic m1;
    logic m2;
    m1 = uses_rs1 && (rs1 == rd);
    m2 = uses_rs2 && (rs2 == rd);
    return memtoreg && (rd != 5'd0) && (m1 || m2);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter16.sv
// Saturating event counter with enable and synchronous clear.
// Ports: clk, clear (sync), enable, count (holds at all-ones).
module sat_counter16
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes,
// data-memory stalls with timeout, and saturating perf counters.
// Ports: clk, reset (sync, high); ID/EX/MEM hazard inputs;
// pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
// mem_timeout, stall_cycles, flush_events.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hz_state_t         state;
  hz_state_t         state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nx;

  logic mem_stall;
  logic load_use;
  logic in_err;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = load_use_hit(ex_memtoreg, ex_rd,
                                  id_rs1, id_uses_rs1,
                                  id_rs2, id_uses_rs2);
  assign in_err    = (state == ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    unique case (state)
      RUN: begin
        wait_nx = '0;
        if (mem_stall) state_nx = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_nx = RUN;
        end else if (wait_cnt == WAIT_W'(WAIT_LIMIT)) begin
          state_nx = ERROR;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      ERROR: begin
        state_nx = ERROR;
      end
      default: begin
        state_nx = RUN;
        wait_nx  = '0;
      end
    endcase
  end

  // One-hot selects encode the priority so the decoder stays flat.
  logic sel_rst;
  logic sel_hold;
  logic sel_br;
  logic sel_lu;

  assign sel_rst  = reset;
  assign sel_hold = !reset && (in_err || mem_stall);
  assign sel_br   = !reset && !in_err && !mem_stall
                    && ex_branch_taken;
  assign sel_lu   = !reset && !in_err && !mem_stall
                    && !ex_branch_taken && load_use;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    unique case (1'b1)
      sel_rst: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      sel_hold: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
      end
      sel_br: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      sel_lu: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_timeout = in_err && !reset;

  sat_counter16 u_stall_cnt (
    .clk    (clk),
    .clear  (reset),
    .enable (!pc_write),
    .count  (stall_cycles)
  );

  sat_counter16 u_flush_cnt (
    .clk    (clk),
    .clear  (reset),
    .enable (ifid_flush),
    .count  (flush_events)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; clock clk.
REQ-003 SHALL have: id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have: id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
REQ-005 SHALL have: ex_rd  in  5  destination register of the instruction in EX.
REQ-006 SHALL have: ex_memtoreg  in  1  the EX instruction is a load.
REQ-007 SHALL have: ex_branch_taken  in  1  branch/jump resolved taken in EX.
REQ-008 SHALL have: mem_req  in  1  the MEM-stage instruction accesses data memory.
REQ-009 SHALL have: mem_ready  in  1  data memory completes the access this cycle.
REQ-010 SHALL have: pc_write, ifid_write  out  1 each  enables for the PC and IF/ID registers.
REQ-011 SHALL have: ifid_flush, idex_flush  out  1 each  zero the IF/ID and ID/EX registers next edge.
REQ-012 SHALL have: pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-013 SHALL have: mem_timeout  out  1  sticky data-memory timeout error.
REQ-014 SHALL have: stall_cycles, flush_events  out  16 each  saturating performance counters.

Function
REQ-015 SHALL compute all control outputs combinationally from inputs and registered state (same-cycle response).
REQ-016 SHALL define mem_stall = mem_req AND NOT mem_ready.
REQ-017 SHALL define load_use = ex_memtoreg AND ex_rd != 0 AND ((id_uses_rs1 AND id_rs1 == ex_rd) OR (id_uses_rs2 AND id_rs2 == ex_rd)).
REQ-018 SHALL apply priority: ERROR state > mem_stall > ex_branch_taken > load_use > none.
REQ-019 SHALL, on mem_stall or in ERROR: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_flush=0; a pending branch or load-use is deferred until the stall clears.
REQ-020 SHALL, on ex_branch_taken (no mem_stall): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, pipe_hold=0; a simultaneous load_use is ignored.
REQ-021 SHALL, on load_use alone: pc_write=0, ifid_write=0, idex_flush=1 (bubble), ifid_flush=0, pipe_hold=0; exactly one bubble per load.
REQ-022 SHALL otherwise drive pc_write=1, ifid_write=1, flushes 0, pipe_hold=0.
REQ-023 SHALL implement FSM states RUN, MEM_WAIT, ERROR.
REQ-024 SHALL transition RUN->MEM_WAIT on mem_stall; MEM_WAIT->RUN on mem_ready or mem_req dropping; MEM_WAIT->ERROR when wait_cnt reaches 255 with mem_stall still true; ERROR is left only by reset.
REQ-025 SHALL keep an 8-bit wait_cnt: cleared in RUN, incremented each MEM_WAIT cycle with mem_stall true, never wrapping.
REQ-026 SHALL assert mem_timeout=1 exactly while in ERROR.
REQ-027 SHALL increment stall_cycles each cycle pc_write=0, saturating at 0xFFFF.
REQ-028 SHALL increment flush_events each cycle ifid_flush=1, saturating at 0xFFFF.

Reset
REQ-029 SHALL, while reset=1, force state RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0, and drive pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
REQ-030 SHALL, with reset asserted mid-wait or in ERROR, return to RUN at the next edge, discarding the wait.

Structure
REQ-031 SHALL place the FSM state enum, WAIT_LIMIT=255 and counter width 16 in the shared core package.
REQ-032 SHALL instantiate one sub-module, sat_counter16 (enable, synchronous clear, saturate), twice for the performance counters.

Verification
REQ-033 SHALL test load-use: ex_memtoreg=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_write=0, idex_flush=1; stall_cycles=1.
REQ-034 SHALL test x0 and unused-source cases: ex_rd=0 or id_uses_rs1=0 with matching numbers -> no stall.
REQ-035 SHALL test branch plus load-use in same cycle -> ifid_flush=1, idex_flush=1, pc_write=1; flush_events=1.
REQ-036 SHALL test mem_req=1, mem_ready=0 for 3 cycles with ex_branch_taken=1 -> pipe_hold=1 for 3 cycles, no flush, then flush on the 4th cycle when mem_ready=1.
REQ-037 SHALL test mem_ready held 0 for 256+ cycles -> mem_timeout=1, pipeline frozen; reset -> mem_timeout=0, state RUN.
REQ-038 SHALL test counter saturation: force 65540 stall cycles -> stall_cycles stays 0xFFFF.
